fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_fifo.sv | 41 ++++
 rtl/fetch_queue.sv | 55 +++++
 tb/tb_fetch_queue.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-queue parameters, FSM states and entry layout
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} fetch_state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular entry buffer with push, pop and synchronous clear
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = fetch_pkg::DEPTH,
  parameter type T = entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic clear,
  input  T     din,
  output T     dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  T mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic do_pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  assign do_pop = pop && count != '0;
  assign dout = mem[head];
  always_ff @(posedge clk)
    if (!rst || clear) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) tail <= inc(tail);
      if (do_pop) head <= inc(head);
      count <= count + CW'(push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (push) mem[tail] <= din;
  // the requester's credit check should make this unreachable
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && count == CW'(DEPTH)));
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC-driven instruction fetch with a credit-limited decode queue
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = fetch_pkg::DEPTH,
  parameter int XLEN = fetch_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic            pc_stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready
);
  localparam int CW = $clog2(DEPTH + 1);
  fetch_state_t state, state_n;
  logic inflight;
  logic [XLEN-1:0] inflight_pc;
  logic [CW-1:0] count;
  logic credit;
  entry_t wr, head;
  always_ff @(posedge clk) state <= !rst ? IDLE : state_n;
  always_comb state_n = state == IDLE ? FETCH : flush ? FLUSH : FETCH;
  // queued entries plus the outstanding response must fit
  assign credit = {1'b0, count} + (CW+1)'(inflight) < (CW+1)'(DEPTH);
  always_comb begin
    imem_req = rst && state == FETCH && !flush && credit;
    pc_stall = !flush && !imem_req;
  end
  assign imem_addr = pc;
  always_ff @(posedge clk) begin
    inflight <= imem_req;
    if (imem_req) inflight_pc <= pc;
  end
  assign wr = '{pc: inflight_pc, instr: imem_rdata};
  fetch_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(inflight && !flush),
    .pop(instr_valid && instr_ready && !flush),
    .clear(flush),
    .din(wr),
    .dout(head),
    .count(count)
  );
  assign instr_valid = rst && count != '0;
  assign instr = head.instr;
  assign instr_pc = head.pc;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a queue-level reference model
module tb_fetch_queue;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 0, flush = 0, instr_ready = 0;
  logic [31:0] pc = 0, imem_rdata = 32'hDEAD_BEEF, target = 0;
  logic pc_stall, imem_req, instr_valid;
  logic [31:0] imem_addr, instr, instr_pc;
  int vectors = 0, errors = 0;
  bit started = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .pc(pc), .flush(flush), .pc_stall(pc_stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  // environment: PC register and one-cycle instruction memory
  always @(posedge clk) begin
    pc <= !rst ? 32'h0 : flush ? target : pc_stall ? pc : pc + 32'h4;
    imem_rdata <= imem_req ? (32'hA000_0000 | imem_addr) : 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // reference model: ordered list of expected entries plus one pending fetch
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  ent_t q[$];
  bit pend = 0, blocked = 1, r_now, r_cmp;
  logic [31:0] pend_pc = 0;

  function automatic bit m_req();
    return rst && !blocked && !flush && (q.size() + int'(pend) < DEPTH);
  endfunction

  always @(posedge clk) begin
    r_now = m_req();
    if (!rst || flush) begin
      q.delete();
      pend = 0;
      blocked = 1;
    end else begin
      if (q.size() != 0 && instr_ready) void'(q.pop_front());
      if (pend) q.push_back('{pend_pc, 32'hA000_0000 | pend_pc});
      pend = r_now;
      pend_pc = pc;
      blocked = 0;
    end
    started = 1;
  end

  always @(negedge clk) if (started) begin
    r_cmp = m_req();
    check("imem_req", imem_req, r_cmp);
    check("pc_stall", pc_stall, !flush && !r_cmp);
    check("imem_addr", imem_addr, pc);
    check("instr_valid", instr_valid, rst && q.size() != 0);
    if (rst && q.size() != 0) begin
      check("instr_pc", instr_pc, q[0].pc);
      check("instr", instr, q[0].instr);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    step(2);
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_stall", pc_stall, 1);
    rst = 1;
    instr_ready = 1;
    #1 check("idle_req", imem_req, 0);
    step;
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 32'h0);
    step(2);
    check("stream_valid", instr_valid, 1);
    check("stream_pc0", instr_pc, 32'h0);
    check("stream_in0", instr, 32'hA000_0000);
    step;
    check("stream_pc4", instr_pc, 32'h4);
    step;
    check("stream_pc8", instr_pc, 32'h8);
    check("stream_in8", instr, 32'hA000_0008);
    step(5);
    rst = 0;
    instr_ready = 0;
    step;
    rst = 1;
    #1 step(5);
    check("bp_req", imem_req, 0);
    check("bp_stall", pc_stall, 1);
    check("bp_pc", pc, 32'h10);
    step;
    check("bp_full_stall", pc_stall, 1);
    check("bp_head", instr_pc, 32'h0);
    instr_ready = 1;
    step;
    check("bp_resume_req", imem_req, 1);
    check("bp_resume_addr", imem_addr, 32'h10);
    check("bp_drain_pc", instr_pc, 32'h4);
    step(8);
    rst = 0;
    instr_ready = 0;
    step;
    rst = 1;
    #1 step(5);
    flush = 1;
    target = 32'h100;
    #1 check("fl_stall", pc_stall, 0);
    check("fl_req", imem_req, 0);
    step;
    flush = 0;
    #1 check("fl_valid", instr_valid, 0);
    check("fl_hold_req", imem_req, 0);
    check("fl_hold_stall", pc_stall, 1);
    check("fl_pc", pc, 32'h100);
    step;
    check("fl_req_tgt", imem_req, 1);
    check("fl_addr_tgt", imem_addr, 32'h100);
    step(2);
    check("fl_first_valid", instr_valid, 1);
    check("fl_first_pc", instr_pc, 32'h100);
    check("fl_first_in", instr, 32'hA000_0100);
    instr_ready = 1;
    step(6);
    instr_ready = 0;
    step(6);
    rst = 0;
    #1 check("mid_rst_req", imem_req, 0);
    check("mid_rst_valid", instr_valid, 0);
    check("mid_rst_stall", pc_stall, 1);
    step;
    rst = 1;
    #1 check("mid_post_valid", instr_valid, 0);
    check("mid_post_req", imem_req, 0);
    step;
    check("mid_req", imem_req, 1);
    check("mid_addr", imem_addr, 32'h0);
    step(2);
    check("mid_first_pc", instr_pc, 32'h0);
    step(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
